// File: rtl/zmon_adc_capture.sv
// -----------------------------------------------------------------------------
// zmon_adc_capture
//
// Autonomous capture engine for the eight Zmon serial ADCs (four forward, four
// reflected). Generates the shared conversion strobe, clocks all ADCs from one
// serial clock, and deserialises the eight SDO lines into result words.
//
// Ports
//   clk100    in   100 MHz system clock, the only clock
//   rst       in   synchronous active-high reset
//   start     in   single-cycle capture request, honoured only when idle
//   period    in   auto-capture period in clk100 cycles, 0 disables auto mode
//   clr_ovr   in   clears the overrun flag (a simultaneous set wins)
//   conv      out  conversion strobe to all ADCs
//   adc_sck   out  shared serial clock, low when idle
//   sdo_f     in   forward ADC serial data, bit i = channel i+1
//   sdo_r     in   reflected ADC serial data, bit i = channel i+1
//   data_f    out  forward results, channel 1 in the least significant word
//   data_r    out  reflected results, same packing
//   valid     out  one-cycle pulse when data_f/data_r update
//   busy      out  high whenever a capture is in progress
//   overrun   out  sticky: an auto tick arrived while a capture was running
// -----------------------------------------------------------------------------
module zmon_adc_capture #(
  parameter int CONV_HI   = 4,
  parameter int CONV_WAIT = 66,
  parameter int SCK_DIV   = 2,
  parameter int NBITS     = 16
) (
  input  logic               clk100,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        period,
  input  logic               clr_ovr,
  output logic               conv,
  output logic               adc_sck,
  input  logic [3:0]         sdo_f,
  input  logic [3:0]         sdo_r,
  output logic [4*NBITS-1:0] data_f,
  output logic [4*NBITS-1:0] data_r,
  output logic               valid,
  output logic               busy,
  output logic               overrun
);

  // One down-counter times every phase (conv high, wait, sck half-period).
  localparam int CW = 16;
  localparam int BW = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [BW-1:0]      r_bit, w_bit_nxt;
  logic               r_conv, w_conv_nxt;
  logic               r_sck, w_sck_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_busy;
  logic               r_ovr;
  logic               w_sample;

  logic [15:0]        r_pcnt;
  logic [15:0]        r_period_q;
  logic               w_period_chg;
  logic               w_tick;
  logic               w_req;

  logic [NBITS-1:0]   r_sh_f [4];
  logic [NBITS-1:0]   r_sh_r [4];
  logic [NBITS-1:0]   w_nx_f [4];
  logic [NBITS-1:0]   w_nx_r [4];
  logic [4*NBITS-1:0] r_data_f, r_data_r;

  // Auto-mode tick: the counter wraps at period-1. A period change restarts the
  // count, and the cycle that sees the change never ticks.
  assign w_period_chg = (period != r_period_q);
  assign w_tick       = (period != 16'd0) && !w_period_chg &&
                        (r_pcnt == period - 16'd1);
  assign w_req        = start || w_tick;

  // Shift-in value: current register moved left with the present SDO bit.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_nx_f[i] = {r_sh_f[i][NBITS-2:0], sdo_f[i]};
      w_nx_r[i] = {r_sh_r[i][NBITS-2:0], sdo_r[i]};
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_conv_nxt  = 1'b0;
    w_sck_nxt   = 1'b0;
    w_valid_nxt = 1'b0;
    w_sample    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_CONV;
          w_cnt_nxt   = CW'(CONV_HI - 1);
          w_conv_nxt  = 1'b1;
        end
      end
      S_CONV: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CW'(CONV_WAIT - 1);
        end else begin
          w_cnt_nxt  = r_cnt - CW'(1);
          w_conv_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = CW'(SCK_DIV - 1);
          w_bit_nxt   = BW'(NBITS);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_SHIFT: begin
        w_sck_nxt = r_sck;
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (!r_sck) begin
          w_sck_nxt = 1'b1;
          w_cnt_nxt = CW'(SCK_DIV - 1);
        end else begin
          // This edge drops SCK; the ADCs have not yet moved SDO, so the
          // current bit is sampled here.
          w_sck_nxt = 1'b0;
          w_sample  = 1'b1;
          w_cnt_nxt = CW'(SCK_DIV - 1);
          w_bit_nxt = r_bit - BW'(1);
          if (r_bit == BW'(1)) begin
            // Results and valid are registered on the final sample edge so
            // they are visible during the DONE cycle.
            w_state_nxt = S_DONE;
            w_valid_nxt = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk100) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_conv     <= 1'b0;
      r_sck      <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_ovr      <= 1'b0;
      r_pcnt     <= '0;
      r_period_q <= '0;
      r_data_f   <= '0;
      r_data_r   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_conv     <= w_conv_nxt;
      r_sck      <= w_sck_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      // A tick outside IDLE sets the flag; set has priority over clear.
      r_ovr      <= (w_tick && (r_state != S_IDLE)) || (r_ovr && !clr_ovr);
      r_period_q <= period;
      if (w_period_chg || (period == 16'd0) || w_tick) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + 16'd1;
      end
      if (w_valid_nxt) begin
        for (int i = 0; i < 4; i++) begin
          r_data_f[i*NBITS +: NBITS] <= w_nx_f[i];
          r_data_r[i*NBITS +: NBITS] <= w_nx_r[i];
        end
      end
    end
  end

  // NOTE: the shift registers carry no reset: every capture shifts in all
  // NBITS bits before they are copied out, so stale content never escapes.
  always_ff @(posedge clk100) begin
    if (w_sample) begin
      for (int i = 0; i < 4; i++) begin
        r_sh_f[i] <= w_nx_f[i];
        r_sh_r[i] <= w_nx_r[i];
      end
    end
  end

  assign conv    = r_conv;
  assign adc_sck = r_sck;
  assign valid   = r_valid;
  assign busy    = r_busy;
  assign overrun = r_ovr;
  assign data_f  = r_data_f;
  assign data_r  = r_data_r;

endmodule

// File: tb/tb_zmon_adc_capture.sv
// -----------------------------------------------------------------------------
// tb_zmon_adc_capture
//
// Two instances: u_a with default timing, u_b with a one-cycle SCK half-period.
// Each has a behavioural ADC model that presents its word MSB first, loading at
// the conv rise and advancing on each SCK falling edge. Expected timing comes
// from the documented edge arithmetic; expected data is the words the models
// were given.
// -----------------------------------------------------------------------------
module tb_zmon_adc_capture;

  localparam int NB        = 16;
  localparam int CONV_HI   = 4;
  localparam int CONV_WAIT = 66;

  logic          clk100 = 1'b0;
  logic          rst, start_a, start_b, clr_ovr;
  logic [15:0]   period;
  logic [3:0]    sdo_f_a = '0, sdo_r_a = '0, sdo_f_b = '0, sdo_r_b = '0;
  logic          conv_a, adc_sck_a, valid_a, busy_a, overrun_a;
  logic          conv_b, adc_sck_b, valid_b, busy_b, overrun_b;
  logic [63:0]   data_f_a, data_r_a, data_f_b, data_r_b;

  always #5 clk100 = ~clk100;

  zmon_adc_capture u_a (
    .clk100 (clk100),  .rst     (rst),       .start  (start_a),
    .period (period),  .clr_ovr (clr_ovr),   .conv   (conv_a),
    .adc_sck(adc_sck_a), .sdo_f (sdo_f_a),   .sdo_r  (sdo_r_a),
    .data_f (data_f_a), .data_r (data_r_a),  .valid  (valid_a),
    .busy   (busy_a),  .overrun (overrun_a)
  );

  zmon_adc_capture #(.SCK_DIV(1)) u_b (
    .clk100 (clk100),  .rst     (rst),       .start  (start_b),
    .period (16'd0),   .clr_ovr (clr_ovr),   .conv   (conv_b),
    .adc_sck(adc_sck_b), .sdo_f (sdo_f_b),   .sdo_r  (sdo_r_b),
    .data_f (data_f_b), .data_r (data_r_b),  .valid  (valid_b),
    .busy   (busy_b),  .overrun (overrun_b)
  );

  int cyc = 0;
  always @(posedge clk100) cyc <= cyc + 1;

  // ---------------- ADC models ----------------
  logic [15:0] wf [2][4];
  logic [15:0] wr [2][4];
  int idx_a = 0, idx_b = 0;

  always @(posedge conv_a or negedge adc_sck_a) begin
    if (conv_a) idx_a = NB - 1;
    else        idx_a = idx_a - 1;
    for (int i = 0; i < 4; i++) begin
      sdo_f_a[i] = (idx_a >= 0) ? wf[0][i][idx_a] : 1'b0;
      sdo_r_a[i] = (idx_a >= 0) ? wr[0][i][idx_a] : 1'b0;
    end
  end

  always @(posedge conv_b or negedge adc_sck_b) begin
    if (conv_b) idx_b = NB - 1;
    else        idx_b = idx_b - 1;
    for (int i = 0; i < 4; i++) begin
      sdo_f_b[i] = (idx_b >= 0) ? wf[1][i][idx_b] : 1'b0;
      sdo_r_b[i] = (idx_b >= 0) ? wr[1][i][idx_b] : 1'b0;
    end
  end

  // ---------------- event monitor (cumulative logs) ----------------
  int   v_q [2][$];
  int   r_q [2][$];
  int   conv_n [2] = '{0, 0};
  logic sck_d [2]  = '{1'b0, 1'b0};

  always @(negedge clk100) begin
    if (valid_a) v_q[0].push_back(cyc);
    if (valid_b) v_q[1].push_back(cyc);
    if (adc_sck_a && !sck_d[0]) r_q[0].push_back(cyc);
    if (adc_sck_b && !sck_d[1]) r_q[1].push_back(cyc);
    if (conv_a) conv_n[0]++;
    if (conv_b) conv_n[1]++;
    sck_d[0] = adc_sck_a;
    sck_d[1] = adc_sck_b;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic goto(input int e);
    while (cyc < e) step();
  endtask

  task automatic set_words(input int sel, input logic [15:0] pf, input logic [15:0] pr, input bit rnd);
    for (int i = 0; i < 4; i++) begin
      wf[sel][i] = rnd ? 16'($urandom) : pf;
      wr[sel][i] = rnd ? 16'($urandom) : pr;
    end
  endtask

  // One capture on instance sel, checked against timing and data expectations.
  task automatic cap(input int sel, input string tag, input bit mid_start);
    int sck_div, e0, v0, r0, c0, t_first, t_valid, bad, nr, v_at;
    logic [63:0] exp_f, exp_r;
    sck_div = (sel == 0) ? 2 : 1;
    v0 = v_q[sel].size();
    r0 = r_q[sel].size();
    c0 = conv_n[sel];
    exp_f = {wf[sel][3], wf[sel][2], wf[sel][1], wf[sel][0]};
    exp_r = {wr[sel][3], wr[sel][2], wr[sel][1], wr[sel][0]};
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    step();
    start_a = 1'b0; start_b = 1'b0;
    e0 = cyc;
    t_first = e0 + CONV_HI + CONV_WAIT + sck_div;
    t_valid = e0 + CONV_HI + CONV_WAIT + 2 * sck_div * NB;
    check({tag, " busy@E0"}, (sel == 0) ? busy_a : busy_b, 1'b1);
    check({tag, " conv@E0"}, (sel == 0) ? conv_a : conv_b, 1'b1);
    if (mid_start) begin
      goto(t_first + 20);
      if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
      step();
      start_a = 1'b0; start_b = 1'b0;
    end
    goto(t_valid + 5);
    check({tag, " conv cycles"}, conv_n[sel] - c0, CONV_HI);
    nr = r_q[sel].size() - r0;
    check({tag, " sck pulses"}, nr, NB);
    bad = 0;
    for (int k = 0; k < nr; k++)
      if (r_q[sel][r0 + k] != t_first + 2 * sck_div * k) bad++;
    check({tag, " sck rise timing errors"}, bad, 0);
    check({tag, " valid count"}, v_q[sel].size() - v0, 1);
    v_at = (v_q[sel].size() > v0) ? v_q[sel][v0] : -1;
    check({tag, " valid latency"}, v_at - e0, t_valid - e0);
    check({tag, " data_f"}, (sel == 0) ? data_f_a : data_f_b, exp_f);
    check({tag, " data_r"}, (sel == 0) ? data_r_a : data_r_b, exp_r);
    check({tag, " overrun"}, (sel == 0) ? overrun_a : overrun_b, 1'b0);
    check({tag, " busy after"}, (sel == 0) ? busy_a : busy_b, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p0, v0, e0, bad, nv;
    logic [63:0] exp_f;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; period = '0; clr_ovr = 1'b0;
    set_words(0, 16'h0, 16'h0, 1'b0);
    set_words(1, 16'h0, 16'h0, 1'b0);
    repeat (3) step();

    // Reset state
    check("rst conv",    conv_a,    1'b0);
    check("rst sck",     adc_sck_a, 1'b0);
    check("rst valid",   valid_a,   1'b0);
    check("rst busy",    busy_a,    1'b0);
    check("rst overrun", overrun_a, 1'b0);
    check("rst data_f",  data_f_a,  64'h0);
    check("rst data_r",  data_r_a,  64'h0);
    check("rst b busy",  busy_b,    1'b0);
    rst = 1'b0;
    step();

    // Single capture with the documented words
    for (int i = 0; i < 4; i++) begin
      wf[0][i] = 16'(16'h1234 + i);
      wr[0][i] = 16'(16'hA000 + i);
    end
    cap(0, "single", 1'b0);
    check("single data_f literal", data_f_a, 64'h1237_1236_1235_1234);

    // start pulsed during SHIFT is ignored
    set_words(0, 16'h0, 16'h0, 1'b1);
    cap(0, "start_in_shift", 1'b1);

    // Auto mode, period 200
    set_words(0, 16'h0, 16'h0, 1'b1);
    exp_f = {wf[0][3], wf[0][2], wf[0][1], wf[0][0]};
    period = 16'd200;
    p0 = cyc + 1;
    v0 = v_q[0].size();
    goto(p0 + 1140);
    period = 16'd0;
    nv = v_q[0].size() - v0;
    check("auto200 valid count", nv, 5);
    bad = 0;
    for (int k = 0; k < nv && k < 5; k++)
      if (v_q[0][v0 + k] != p0 + 200 * (k + 1) + 134) bad++;
    check("auto200 valid spacing errors", bad, 0);
    check("auto200 overrun", overrun_a, 1'b0);
    check("auto200 data_f", data_f_a, exp_f);
    repeat (5) step();

    // Auto mode, period 100: every other tick collides with a capture
    period = 16'd100;
    p0 = cyc + 1;
    v0 = v_q[0].size();
    goto(p0 + 199);
    check("auto100 overrun before 2nd tick", overrun_a, 1'b0);
    goto(p0 + 200);
    check("auto100 overrun after 2nd tick", overrun_a, 1'b1);
    goto(p0 + 399);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("auto100 clr with tick", overrun_a, 1'b1);
    goto(p0 + 449);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("auto100 clr alone", overrun_a, 1'b0);
    goto(p0 + 640);
    period = 16'd0;
    nv = v_q[0].size() - v0;
    check("auto100 valid count", nv, 3);
    bad = 0;
    for (int k = 0; k < nv && k < 3; k++)
      if (v_q[0][v0 + k] != p0 + 100 * (2 * k + 1) + 134) bad++;
    check("auto100 valid spacing errors", bad, 0);
    check("auto100 overrun re-set by 6th tick", overrun_a, 1'b1);
    repeat (5) step();

    // Reset in the middle of SHIFT
    set_words(0, 16'h0, 16'h0, 1'b1);
    v0 = v_q[0].size();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    e0 = cyc;
    goto(e0 + 100);
    check("pre-rst sck activity busy", busy_a, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst conv",    conv_a,    1'b0);
    check("midrst sck",     adc_sck_a, 1'b0);
    check("midrst busy",    busy_a,    1'b0);
    check("midrst valid",   valid_a,   1'b0);
    check("midrst overrun", overrun_a, 1'b0);
    check("midrst data_f",  data_f_a,  64'h0);
    check("midrst data_r",  data_r_a,  64'h0);
    goto(e0 + 300);
    check("midrst no valid", v_q[0].size() - v0, 0);
    set_words(0, 16'h0, 16'h0, 1'b1);
    cap(0, "after_rst", 1'b0);

    // Fast SCK instance: fixed patterns then random words
    set_words(1, 16'hFFFF, 16'hFFFF, 1'b0);
    cap(1, "fast ones", 1'b0);
    set_words(1, 16'h0000, 16'h0000, 1'b0);
    cap(1, "fast zeros", 1'b0);
    set_words(1, 16'h5555, 16'h5555, 1'b0);
    cap(1, "fast 5555", 1'b0);
    set_words(1, 16'hAAAA, 16'h5555, 1'b0);
    cap(1, "fast aaaa", 1'b0);
    for (int n = 0; n < 3; n++) begin
      set_words(1, 16'h0, 16'h0, 1'b1);
      cap(1, "fast random", 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
